// File: rtl/tree_route_input_ctrl.sv
// Input-control stage of a NoC tree router: buffers packets in a small FIFO and
// steers the head packet to child0, child1 or the parent by its destination address.
module tree_route_input_ctrl #(
  parameter int WIDTH_packet = 14,
  parameter int ADDR_W       = 4,
  parameter int PREFIX_W     = 0,
  parameter int PREFIX       = 0,
  parameter int DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH_packet-1:0]      in_data,
  output logic                         c0_valid,
  input  logic                         c0_ready,
  output logic [WIDTH_packet-1:0]      c0_data,
  output logic                         c1_valid,
  input  logic                         c1_ready,
  output logic [WIDTH_packet-1:0]      c1_data,
  output logic                         p_valid,
  input  logic                         p_ready,
  output logic [WIDTH_packet-1:0]      p_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [15:0]                  pkt_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  // Bit of the packet that picks the child once the subtree prefix matches.
  localparam int CHILD_BIT = WIDTH_packet - 1 - PREFIX_W;
  localparam int DEST_LSB  = WIDTH_packet - ADDR_W;

  typedef enum logic [1:0] {
    ROUTE_C0 = 2'd0,
    ROUTE_C1 = 2'd1,
    ROUTE_P  = 2'd2
  } route_t;

  logic [WIDTH_packet-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [OCC_W-1:0]        count_q;
  logic [WIDTH_packet-1:0] head;
  logic                    not_empty;
  logic                    in_subtree;
  logic                    sel_ready;
  logic                    push;
  logic                    pop;
  route_t                  route;

  assign head      = mem[rd_ptr];
  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != OCC_W'(DEPTH));
  assign occupancy = count_q;

  // The root owns the whole address space, so every packet goes to a child.
  if (PREFIX_W == 0) begin : g_root
    assign in_subtree = 1'b1;
  end else begin : g_subtree
    assign in_subtree = (head[WIDTH_packet-1 -: PREFIX_W] == PREFIX_W'(PREFIX));
  end

  always_comb begin
    route = ROUTE_P;
    if (in_subtree) begin
      route = head[CHILD_BIT] ? ROUTE_C1 : ROUTE_C0;
    end
  end

  always_comb begin
    c0_valid  = 1'b0;
    c1_valid  = 1'b0;
    p_valid   = 1'b0;
    sel_ready = 1'b0;
    case (route)
      ROUTE_C0: begin
        c0_valid  = not_empty;
        sel_ready = c0_ready;
      end
      ROUTE_C1: begin
        c1_valid  = not_empty;
        sel_ready = c1_ready;
      end
      default: begin
        p_valid   = not_empty;
        sel_ready = p_ready;
      end
    endcase
  end

  // All three data ports show the head; only the matching valid qualifies it.
  assign c0_data = head;
  assign c1_data = head;
  assign p_data  = head;

  assign push = in_valid && in_ready;
  assign pop  = not_empty && sel_ready;

  // Storage is not reset: an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      pkt_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        pkt_count <= pkt_count + 16'd1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  logic [ADDR_W-1:0] unused_dest;
  assign unused_dest = head[DEST_LSB +: ADDR_W];

endmodule

// File: tb/tb_tree_route_input_ctrl.sv
// Directed bench for tree_route_input_ctrl: a root instance (a_*) and a
// PREFIX_W=1/PREFIX=1 instance (b_*), checked with a queue scoreboard.
module tb_tree_route_input_ctrl;
  localparam int W = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         a_rst = 1'b1, b_rst = 1'b1;
  logic         a_in_valid = 1'b0, b_in_valid = 1'b0;
  logic [W-1:0] a_in_data = '0, b_in_data = '0;
  logic         a_c0_ready = 1'b0, a_c1_ready = 1'b0, a_p_ready = 1'b0;
  logic         b_c0_ready = 1'b0, b_c1_ready = 1'b0, b_p_ready = 1'b0;
  logic         a_in_ready, a_c0_valid, a_c1_valid, a_p_valid;
  logic         b_in_ready, b_c0_valid, b_c1_valid, b_p_valid;
  logic [W-1:0] a_c0_data, a_c1_data, a_p_data;
  logic [W-1:0] b_c0_data, b_c1_data, b_p_data;
  logic [2:0]   a_occupancy, b_occupancy;
  logic [15:0]  a_pkt_count, b_pkt_count;

  tree_route_input_ctrl u_root (
    .clk(clk), .rst(a_rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .c0_valid(a_c0_valid), .c0_ready(a_c0_ready), .c0_data(a_c0_data),
    .c1_valid(a_c1_valid), .c1_ready(a_c1_ready), .c1_data(a_c1_data),
    .p_valid(a_p_valid), .p_ready(a_p_ready), .p_data(a_p_data),
    .occupancy(a_occupancy), .pkt_count(a_pkt_count)
  );

  tree_route_input_ctrl #(.PREFIX_W(1), .PREFIX(1)) u_sub (
    .clk(clk), .rst(b_rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .c0_valid(b_c0_valid), .c0_ready(b_c0_ready), .c0_data(b_c0_data),
    .c1_valid(b_c1_valid), .c1_ready(b_c1_ready), .c1_data(b_c1_data),
    .p_valid(b_p_valid), .p_ready(b_p_ready), .p_data(b_p_data),
    .occupancy(b_occupancy), .pkt_count(b_pkt_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  int exp_cnt = 0;
  int a_p_seen = 0;
  int n_rx = 0;
  int rx_base = 0;

  // Handshake monitor on the root instance.
  always @(posedge clk) begin
    if (a_p_valid) a_p_seen++;
    if ((a_c0_valid && a_c0_ready) || (a_c1_valid && a_c1_ready) || (a_p_valid && a_p_ready))
      n_rx++;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: observed no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One root cycle: check head/route against the scoreboard, predict the
  // handshakes from the bench's own route decode, then clock.
  task automatic step_a();
    logic         push_e;
    logic         pop_e;
    logic [W-1:0] head;
    logic         to_c1;
    push_e = a_in_valid && (exp_q.size() != 4);
    pop_e  = 1'b0;
    chk("in_ready", 32'(a_in_ready), 32'(exp_q.size() != 4));
    if (exp_q.size() != 0) begin
      head  = exp_q[0];
      to_c1 = head[W-1];
      chk("c0_valid", 32'(a_c0_valid), 32'(!to_c1));
      chk("c1_valid", 32'(a_c1_valid), 32'(to_c1));
      chk("p_valid", 32'(a_p_valid), 32'd0);
      chk("c0_data", 32'(a_c0_data), 32'(head));
      chk("c1_data", 32'(a_c1_data), 32'(head));
      chk("p_data", 32'(a_p_data), 32'(head));
      pop_e = to_c1 ? a_c1_ready : a_c0_ready;
    end else begin
      chk("idle_valids", 32'({a_c0_valid, a_c1_valid, a_p_valid}), 32'd0);
    end
    if (pop_e) begin
      void'(exp_q.pop_front());
      exp_cnt++;
    end
    if (push_e) exp_q.push_back(a_in_data);
    tick();
    chk("occupancy", 32'(a_occupancy), 32'(exp_q.size()));
    chk("pkt_count", 32'(a_pkt_count), 32'(exp_cnt[15:0]));
  endtask

  initial begin
    // Reset both instances
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0;
    b_rst = 1'b0;
    chk("rst_occ", 32'(a_occupancy), 32'd0);
    chk("rst_cnt", 32'(a_pkt_count), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_valids", 32'({a_c0_valid, a_c1_valid, a_p_valid}), 32'd0);
    chk("rst_b_valids", 32'({b_c0_valid, b_c1_valid, b_p_valid}), 32'd0);

    // 1: root routing by dest MSB, one-cycle latency
    a_c0_ready = 1'b1; a_c1_ready = 1'b1; a_p_ready = 1'b1;
    a_in_valid = 1'b1; a_in_data = 14'b0000_0000000001;
    step_a();
    chk("t1_c0_valid", 32'(a_c0_valid), 32'd1);
    chk("t1_c0_data", 32'(a_c0_data), 32'h0001);
    a_in_data = 14'b1000_0000000010;
    step_a();
    chk("t1_c1_valid", 32'(a_c1_valid), 32'd1);
    chk("t1_c1_data", 32'(a_c1_data), 32'h2002);
    chk("t1_c0_low", 32'(a_c0_valid), 32'd0);
    a_in_valid = 1'b0;
    step_a();
    chk("t1_count", 32'(a_pkt_count), 32'd2);
    chk("t1_occ", 32'(a_occupancy), 32'd0);

    // 2: subtree prefix 1: parent, c0, c1
    b_c0_ready = 1'b1; b_c1_ready = 1'b1; b_p_ready = 1'b1;
    b_in_valid = 1'b1; b_in_data = 14'b0110_0000000011;
    tick();
    chk("t2_p_valid", 32'({b_c0_valid, b_c1_valid, b_p_valid}), 32'b001);
    chk("t2_p_data", 32'(b_p_data), 32'h1803);
    chk("t2_occ", 32'(b_occupancy), 32'd1);
    b_in_data = 14'b1010_0000000100;
    tick();
    chk("t2_c0_valid", 32'({b_c0_valid, b_c1_valid, b_p_valid}), 32'b100);
    chk("t2_c0_data", 32'(b_c0_data), 32'h2804);
    b_in_data = 14'b1110_0000000101;
    tick();
    chk("t2_c1_valid", 32'({b_c0_valid, b_c1_valid, b_p_valid}), 32'b010);
    chk("t2_c1_data", 32'(b_c1_data), 32'h3805);
    b_in_valid = 1'b0;
    tick();
    chk("t2_idle", 32'({b_c0_valid, b_c1_valid, b_p_valid}), 32'd0);
    chk("t2_count", 32'(b_pkt_count), 32'd3);
    chk("t2_in_ready", 32'(b_in_ready), 32'd1);

    // 3: fill to full with all ready low, then drain through c0
    a_c0_ready = 1'b0; a_c1_ready = 1'b0; a_p_ready = 1'b0;
    a_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_data = 14'(i + 16);
      chk("t3_accepting", 32'(a_in_ready), 32'd1);
      step_a();
    end
    a_in_data = 14'(20);
    chk("t3_full_ready", 32'(a_in_ready), 32'd0);
    chk("t3_full_occ", 32'(a_occupancy), 32'd4);
    step_a();
    step_a();
    chk("t3_held_data", 32'(a_c0_data), 32'd16);
    a_c0_ready = 1'b1;
    step_a();
    chk("t3_first_pop_occ", 32'(a_occupancy), 32'd3);
    chk("t3_reopen", 32'(a_in_ready), 32'd1);
    step_a();
    chk("t3_fifth_in_occ", 32'(a_occupancy), 32'd3);
    a_in_valid = 1'b0;
    repeat (3) step_a();
    chk("t3_drained", 32'(a_occupancy), 32'd0);

    // 4: steady push and pop at occupancy 2
    a_c0_ready = 1'b0; a_c1_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 14'h0005;
    step_a();
    a_in_data = 14'h2006;
    step_a();
    a_c0_ready = 1'b1; a_c1_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_in_data = {4'(i * 3), 10'(i + 100)};
      step_a();
      chk("t4_occ2", 32'(a_occupancy), 32'd2);
    end
    a_in_valid = 1'b0;
    for (int j = 0; j < 6 && exp_q.size() != 0; j++) step_a();
    chk("t4_empty", 32'(exp_q.size()), 32'd0);

    // 5: async reset with three packets buffered toward a stalled c1
    a_c0_ready = 1'b0; a_c1_ready = 1'b0;
    a_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_in_data = 14'h2000 | 14'(k + 1);
      step_a();
    end
    a_in_valid = 1'b0;
    chk("t5_pre_occ", 32'(a_occupancy), 32'd3);
    #2;
    a_rst = 1'b1;
    #1;
    chk("t5_async_valids", 32'({a_c0_valid, a_c1_valid, a_p_valid}), 32'd0);
    chk("t5_async_occ", 32'(a_occupancy), 32'd0);
    chk("t5_async_cnt", 32'(a_pkt_count), 32'd0);
    chk("t5_async_ready", 32'(a_in_ready), 32'd1);
    exp_q.delete();
    exp_cnt = 0;
    tick();
    a_rst = 1'b0;
    a_c0_ready = 1'b1; a_c1_ready = 1'b1;
    repeat (3) step_a();

    // 6: 65537 forwarded packets wrap pkt_count to 1
    rx_base = n_rx;
    a_in_valid = 1'b1;
    for (int k = 0; k < 65537; k++) begin
      a_in_data = 14'(k ^ (k >> 3));
      step_a();
    end
    a_in_valid = 1'b0;
    for (int j = 0; j < 8 && exp_q.size() != 0; j++) step_a();
    chk("t6_all_received", 32'(exp_q.size()), 32'd0);
    chk("t6_rx_total", 32'(n_rx - rx_base), 32'd65537);
    chk("t6_count_wrap", 32'(a_pkt_count), 32'd1);

    chk("root_p_never", 32'(a_p_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
